// File: rtl/des_key_schedule.sv
// DES key schedule: expands a 64-bit key into 16 round subkeys, one per clock,
// and packs them into a 768-bit bundle (slot 1 in the top 48 bits).
// Optional feature macro: DES_KEY_PARITY_CHK_EN adds key_in odd-parity checking;
// without it parity_err is tied low.
module des_key_schedule (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [63:0]  key_in,
  input  logic         decrypt,
  output logic         busy,
  output logic         done,
  output logic         keys_valid,
  output logic [767:0] round_keys,
  output logic         parity_err
);

  localparam int unsigned KEY_W      = 64;
  localparam int unsigned HALF_W     = 28;
  localparam int unsigned CD_W       = 56;
  localparam int unsigned SUBKEY_W   = 48;
  localparam int unsigned NUM_ROUNDS = 16;
  localparam int unsigned BUNDLE_W   = 768;
  localparam int unsigned RND_W      = 4;

  // PC-1: DES bit numbers (1 = key MSB) feeding C (first 28) then D
  localparam int unsigned PC1_TBL [CD_W] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  // PC-2: positions (1 = C MSB) of the concatenated C,D selected per subkey bit
  localparam int unsigned PC2_TBL [SUBKEY_W] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  // Bit r set when round r rotates by two (otherwise by one)
  localparam logic [NUM_ROUNDS-1:0] SHIFT_TWO = 16'b0111_1110_1111_1100;

  typedef enum logic [1:0] {IDLE, GEN, DONE} state_t;

  function automatic logic [CD_W-1:0] pc1(input logic [KEY_W-1:0] k);
    logic [CD_W-1:0] r;
    r = '0;
    for (int i = 0; i < int'(CD_W); i++)
      r[6'(CD_W - 1 - i)] = k[6'(KEY_W - PC1_TBL[i])];
    return r;
  endfunction

  function automatic logic [SUBKEY_W-1:0] pc2(input logic [CD_W-1:0] cd);
    logic [SUBKEY_W-1:0] r;
    r = '0;
    for (int i = 0; i < int'(SUBKEY_W); i++)
      r[6'(SUBKEY_W - 1 - i)] = cd[6'(CD_W - PC2_TBL[i])];
    return r;
  endfunction

  function automatic logic [HALF_W-1:0] rotl(input logic [HALF_W-1:0] h, input logic two);
    return two ? {h[HALF_W-3:0], h[HALF_W-1:HALF_W-2]} : {h[HALF_W-2:0], h[HALF_W-1]};
  endfunction

  state_t               state, state_nxt;
  logic [RND_W-1:0]     rnd;
  logic [HALF_W-1:0]    c_reg, d_reg;
  logic                 dec_reg;
  logic                 load_c, gen_c, last_c, fin_c;
  logic [HALF_W-1:0]    c_rot_c, d_rot_c;
  logic [SUBKEY_W-1:0]  subkey_c;
  logic [RND_W-1:0]     slot_idx_c;
  logic [CD_W-1:0]      cd_init_c;

  // Rotate the halves for this round, derive the subkey and its destination slot
  always_comb begin
    c_rot_c    = rotl(c_reg, SHIFT_TWO[rnd]);
    d_rot_c    = rotl(d_reg, SHIFT_TWO[rnd]);
    subkey_c   = pc2({c_rot_c, d_rot_c});
    slot_idx_c = dec_reg ? (4'd15 - rnd) : rnd;
    cd_init_c  = pc1(key_in);
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and datapath enables
  always_comb begin
    state_nxt = state;
    load_c    = 1'b0;
    gen_c     = 1'b0;
    last_c    = 1'b0;
    fin_c     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load_c    = 1'b1;
          state_nxt = GEN;
        end
      end
      GEN: begin
        gen_c = 1'b1;
        if (rnd == RND_W'(NUM_ROUNDS - 1)) begin
          last_c    = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        fin_c     = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Key halves, round counter, bundle and handshake outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_reg      <= '0;
      d_reg      <= '0;
      dec_reg    <= 1'b0;
      rnd        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      keys_valid <= 1'b0;
      round_keys <= '0;
    end else begin
      done <= 1'b0;
      if (load_c) begin
        c_reg      <= cd_init_c[CD_W-1:HALF_W];
        d_reg      <= cd_init_c[HALF_W-1:0];
        dec_reg    <= decrypt;
        rnd        <= '0;
        keys_valid <= 1'b0;
        busy       <= 1'b1;
      end
      if (gen_c) begin
        c_reg <= c_rot_c;
        d_reg <= d_rot_c;
        rnd   <= rnd + RND_W'(1);
        for (int s = 0; s < int'(NUM_ROUNDS); s++) begin
          if (slot_idx_c == RND_W'(s))
            round_keys[10'(BUNDLE_W - 1 - SUBKEY_W * s) -: SUBKEY_W] <= subkey_c;
        end
        if (last_c) done <= 1'b1;
      end
      if (fin_c) begin
        busy       <= 1'b0;
        keys_valid <= 1'b1;
      end
    end
  end

`ifdef DES_KEY_PARITY_CHK_EN
  // Flag any key byte with an even ones-count, captured at start accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity_err <= 1'b0;
    end else if (load_c) begin
      parity_err <= 1'b0;
      for (int b = 0; b < int'(KEY_W / 8); b++)
        if (~^key_in[8*b +: 8]) parity_err <= 1'b1;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_des_key_schedule.sv
// Self-checking bench for des_key_schedule: directed DES vectors plus random
// keys checked against a table-driven DES key-schedule reference model.
module tb_des_key_schedule;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [63:0]  key_in;
  logic         decrypt;
  logic         busy;
  logic         done;
  logic         keys_valid;
  logic [767:0] round_keys;
  logic         parity_err;

  int checks = 0;
  int errors = 0;

  localparam logic [63:0] KEY_T1  = 64'h133457799BBCDFF1;
  localparam logic [63:0] KEY_BAD = 64'h133457799BBCDFF0;
  localparam logic [47:0] K1_T1   = 48'h1B02EFFC7072;
  localparam logic [47:0] K16_T1  = 48'hCB3D8B0E17F5;

  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  des_key_schedule dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .key_in     (key_in),
    .decrypt    (decrypt),
    .busy       (busy),
    .done       (done),
    .keys_valid (keys_valid),
    .round_keys (round_keys),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  // Subkey n (1..16): C0/D0 rotated by the cumulative shift count, then PC-2
  function automatic logic [47:0] ref_subkey(input logic [63:0] key, input int n);
    logic [27:0] c0, d0, cn, dn;
    logic [55:0] cd;
    logic [47:0] k;
    int total;
    total = 0;
    for (int i = 0; i < n; i++) total += SHIFTS[i];
    c0 = '0;
    d0 = '0;
    for (int i = 0; i < 28; i++) begin
      c0 = {c0[26:0], key[6'(64 - PC1_T[i])]};
      d0 = {d0[26:0], key[6'(64 - PC1_T[28 + i])]};
    end
    cn = (c0 << total) | (c0 >> (28 - total));
    dn = (d0 << total) | (d0 >> (28 - total));
    cd = {cn, dn};
    k = '0;
    for (int i = 0; i < 48; i++) k = {k[46:0], cd[6'(56 - PC2_T[i])]};
    return k;
  endfunction

  function automatic logic [767:0] ref_bundle(input logic [63:0] key, input logic dec);
    logic [767:0] b;
    b = '0;
    for (int s = 1; s <= 16; s++) b = {b[719:0], ref_subkey(key, dec ? 17 - s : s)};
    return b;
  endfunction

  function automatic logic ref_parity(input logic [63:0] key);
    logic bad;
    bad = 1'b0;
`ifdef DES_KEY_PARITY_CHK_EN
    for (int b = 0; b < 8; b++) if ($countones(key[8*b +: 8]) % 2 == 0) bad = 1'b1;
`endif
    return bad;
  endfunction

  task automatic check(input string tag, input logic [767:0] obs, input logic [767:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 768'(busy), 768'(0));
    check({tag, "_done"}, 768'(done), 768'(0));
    check({tag, "_kv"},   768'(keys_valid), 768'(0));
    check({tag, "_keys"}, round_keys, 768'(0));
    check({tag, "_par"},  768'(parity_err), 768'(0));
  endtask

  // One schedule run; optionally pulses a stray start (key 0) mid-generation
  task automatic run_sched(input string tag, input logic [63:0] key, input logic dec,
                           input bit inject);
    int k;
    logic [767:0] exp;
    exp = ref_bundle(key, dec);
    @(negedge clk);
    start = 1'b1; key_in = key; decrypt = dec;
    @(negedge clk);
    start = 1'b0; key_in = {$urandom, $urandom}; decrypt = ~dec;
    check({tag, "_acc_busy"}, 768'(busy), 768'(1));
    check({tag, "_acc_kv"},   768'(keys_valid), 768'(0));
    k = 0;
    while (done !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
      if (inject && k == 5) begin
        start = 1'b1; key_in = 64'h0; decrypt = ~dec;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check({tag, "_latency"}, 768'(k), 768'(16));
    check({tag, "_done_busy"}, 768'(busy), 768'(1));
    @(negedge clk);
    check({tag, "_done_once"}, 768'(done), 768'(0));
    check({tag, "_busy_off"},  768'(busy), 768'(0));
    check({tag, "_kv"},        768'(keys_valid), 768'(1));
    check({tag, "_bundle"},    round_keys, exp);
    check({tag, "_par"},       768'(parity_err), 768'(ref_parity(key)));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; key_in = '0; decrypt = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // T1: known-answer encrypt order
    run_sched("t1", KEY_T1, 1'b0, 1'b0);
    check("t1_slot1",  768'(round_keys[767 -: 48]), 768'(K1_T1));
    check("t1_slot16", 768'(round_keys[47:0]), 768'(K16_T1));
    repeat (3) @(negedge clk);
    check("t1_hold", round_keys, ref_bundle(KEY_T1, 1'b0));

    // T2: decrypt order is reversed
    run_sched("t2", KEY_T1, 1'b1, 1'b0);
    check("t2_slot1",  768'(round_keys[767 -: 48]), 768'(K16_T1));
    check("t2_slot16", 768'(round_keys[47:0]), 768'(K1_T1));

    // T3: start while busy is ignored
    run_sched("t3", KEY_T1, 1'b0, 1'b1);

    // T4: reset mid-generation aborts, then a clean run
    @(negedge clk);
    start = 1'b1; key_in = KEY_T1; decrypt = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_outputs("t4_abort");
    @(negedge clk);
    rst = 1'b0;
    check("t4_idle_kv", 768'(keys_valid), 768'(0));
    run_sched("t4", KEY_T1, 1'b0, 1'b0);

    // T5: key with an even-parity byte still schedules correctly
    run_sched("t5", KEY_BAD, 1'b0, 1'b0);
    check("t5_slot1", 768'(round_keys[767 -: 48]), 768'(K1_T1));
    run_sched("t5_ok", KEY_T1, 1'b0, 1'b0);

    // T6 + random: back-to-back runs with toggling mode
    run_sched("t6_enc", KEY_T1, 1'b0, 1'b0);
    run_sched("t6_dec", KEY_T1, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++)
      run_sched($sformatf("rnd%0d", i), {$urandom, $urandom}, 1'($urandom_range(0, 1)), 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
